lii_stream_wrapper_pk: RTL and testbench

Parametrised successor of the single-stream LII-to-HLS-kernel adapter in the stream config layer. One LII phy input channel feeds the kernel input stream through a first-word-fall-through FIFO, with destination filtering. Narrow kernel output words are packed into full PW-bit LII beats with lane keep. The packer optionally flushes partial beats on an idle timeout.

---
 rtl/lii_stream_wrapper_pk.sv | 153 +++++++++++++++
 tb/tb_lii_stream_wrapper_pk.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lii_stream_wrapper_pk.sv
// LII phy <-> HLS kernel stream adapter: filtered FWFT input FIFO and lane packer with tkeep.
// Optional idle-timeout flush of partial beats is enabled by defining LII_PACK_TIMEOUT_EN.
module lii_stream_wrapper_pk #(
  parameter int unsigned IN_W         = 24,
  parameter int unsigned OUT_W        = 8,
  parameter int unsigned PW           = 64,
  parameter int unsigned DEPTH        = 8,
  parameter logic [7:0]  LOCAL_ID     = 8'h00,
  parameter logic [7:0]  DEST_ID      = 8'h01,
  parameter int unsigned FLUSH_CYCLES = 16,
  localparam int unsigned PACK        = PW / OUT_W
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic [PW-1:0]     lii_in_p0_tdata,
  input  logic              lii_in_p0_tvalid,
  output logic              lii_in_p0_tready,
  input  logic [7:0]        lii_in_p0_src,
  input  logic [7:0]        lii_in_p0_dst,
  output logic [PW-1:0]     lii_out_p0_tdata,
  output logic              lii_out_p0_tvalid,
  input  logic              lii_out_p0_tready,
  output logic [PACK-1:0]   lii_out_p0_tkeep,
  output logic [7:0]        lii_out_p0_src,
  output logic [7:0]        lii_out_p0_dst,
  output logic [IN_W-1:0]   pixel_stream_tdata,
  output logic              pixel_stream_tvalid,
  input  logic              pixel_stream_tready,
  input  logic [OUT_W-1:0]  frame_stream_tdata,
  input  logic              frame_stream_tvalid,
  output logic              frame_stream_tready,
  output logic              ce,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(PACK + 1);

  // ---------------- input filter and FWFT FIFO ----------------
  logic [IN_W-1:0] mem [DEPTH];
  logic [AW:0]     wptr, rptr;
  logic            full, empty, push, pop, drop;
  logic            unused_in;

  assign unused_in = ^{lii_in_p0_src, lii_in_p0_tdata};

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign push  = lii_in_p0_tvalid && !full && (lii_in_p0_dst == LOCAL_ID);
  assign drop  = lii_in_p0_tvalid && !full && (lii_in_p0_dst != LOCAL_ID);
  assign pop   = !empty && pixel_stream_tready;

  assign lii_in_p0_tready    = !full;
  assign pixel_stream_tvalid = !empty;
  assign pixel_stream_tdata  = mem[rptr[AW-1:0]];

  always_ff @(posedge aclk) begin
    if (arst) begin
      wptr     <= '0;
      rptr     <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wptr[AW-1:0]] <= lii_in_p0_tdata[IN_W-1:0];
  end

  // ---------------- output packer ----------------
  logic [PW-1:0]   acc, obuf, acc_masked;
  logic [PACK-1:0] okeep, keep_mask;
  logic [CW-1:0]   cnt;
  logic            ov, fl, acc_ready, transfer, accept;

  assign acc_ready = (cnt == CW'(PACK)) || fl;
  assign transfer  = acc_ready && (!ov || lii_out_p0_tready);
  assign frame_stream_tready = ((cnt < CW'(PACK)) && !fl) || transfer;
  assign accept    = frame_stream_tvalid && frame_stream_tready;
  assign ce        = frame_stream_tready;

  always_comb begin
    keep_mask  = '0;
    acc_masked = '0;
    for (int i = 0; i < int'(PACK); i++) begin
      if (i < int'(cnt)) begin
        keep_mask[i]                   = 1'b1;
        acc_masked[i*OUT_W +: OUT_W]   = acc[i*OUT_W +: OUT_W];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      acc   <= '0;
      cnt   <= '0;
      obuf  <= '0;
      okeep <= '0;
      ov    <= 1'b0;
    end else if (transfer) begin
      obuf  <= acc_masked;
      okeep <= keep_mask;
      ov    <= 1'b1;
      acc   <= '0;
      cnt   <= '0;
      // A word arriving alongside the transfer starts the next beat in lane 0.
      if (accept) begin
        acc[OUT_W-1:0] <= frame_stream_tdata;
        cnt            <= CW'(1);
      end
    end else begin
      if (lii_out_p0_tready) ov <= 1'b0;
      if (accept) begin
        acc[int'(cnt)*OUT_W +: OUT_W] <= frame_stream_tdata;
        cnt                           <= cnt + CW'(1);
      end
    end
  end

`ifdef LII_PACK_TIMEOUT_EN
  logic [15:0] idle;

  always_ff @(posedge aclk) begin
    if (arst) begin
      idle <= '0;
      fl   <= 1'b0;
    end else begin
      if (accept || transfer || cnt == '0) begin
        idle <= '0;
      end else if (idle != 16'(FLUSH_CYCLES)) begin
        idle <= idle + 16'd1;
      end
      if (transfer) begin
        fl <= 1'b0;
      end else if (idle == 16'(FLUSH_CYCLES) && cnt != '0 && cnt != CW'(PACK)) begin
        fl <= 1'b1;
      end
    end
  end
`else
  assign fl = 1'b0;
`endif

  assign lii_out_p0_tdata  = obuf;
  assign lii_out_p0_tkeep  = okeep;
  assign lii_out_p0_tvalid = ov;
  assign lii_out_p0_src    = LOCAL_ID;
  assign lii_out_p0_dst    = DEST_ID;

endmodule

// File: tb/tb_lii_stream_wrapper_pk.sv
// Scoreboard bench for lii_stream_wrapper_pk: directed stimulus, queued expectations,
// negedge monitor for both output streams.
module tb_lii_stream_wrapper_pk;

  logic        aclk = 1'b0;
  logic        arst;
  logic [63:0] lii_in_p0_tdata;
  logic        lii_in_p0_tvalid;
  logic        lii_in_p0_tready;
  logic [7:0]  lii_in_p0_src;
  logic [7:0]  lii_in_p0_dst;
  logic [63:0] lii_out_p0_tdata;
  logic        lii_out_p0_tvalid;
  logic        lii_out_p0_tready;
  logic [7:0]  lii_out_p0_tkeep;
  logic [7:0]  lii_out_p0_src;
  logic [7:0]  lii_out_p0_dst;
  logic [23:0] pixel_stream_tdata;
  logic        pixel_stream_tvalid;
  logic        pixel_stream_tready;
  logic [7:0]  frame_stream_tdata;
  logic        frame_stream_tvalid;
  logic        frame_stream_tready;
  logic        ce;
  logic [15:0] drop_cnt;

  always #5 aclk = ~aclk;

  lii_stream_wrapper_pk dut (
    .aclk                (aclk),
    .arst                (arst),
    .lii_in_p0_tdata     (lii_in_p0_tdata),
    .lii_in_p0_tvalid    (lii_in_p0_tvalid),
    .lii_in_p0_tready    (lii_in_p0_tready),
    .lii_in_p0_src       (lii_in_p0_src),
    .lii_in_p0_dst       (lii_in_p0_dst),
    .lii_out_p0_tdata    (lii_out_p0_tdata),
    .lii_out_p0_tvalid   (lii_out_p0_tvalid),
    .lii_out_p0_tready   (lii_out_p0_tready),
    .lii_out_p0_tkeep    (lii_out_p0_tkeep),
    .lii_out_p0_src      (lii_out_p0_src),
    .lii_out_p0_dst      (lii_out_p0_dst),
    .pixel_stream_tdata  (pixel_stream_tdata),
    .pixel_stream_tvalid (pixel_stream_tvalid),
    .pixel_stream_tready (pixel_stream_tready),
    .frame_stream_tdata  (frame_stream_tdata),
    .frame_stream_tvalid (frame_stream_tvalid),
    .frame_stream_tready (frame_stream_tready),
    .ce                  (ce),
    .drop_cnt            (drop_cnt)
  );

  logic [71:0] out_q[$];   // {tdata, tkeep}
  logic [23:0] pix_q[$];
  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [71:0] e;
    forever begin
      @(negedge aclk);
      if (!arst && lii_out_p0_tvalid && lii_out_p0_tready) begin
        if (out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected actual=%h/%h required=no beat",
                   lii_out_p0_tdata, lii_out_p0_tkeep);
        end else begin
          e = out_q.pop_front();
          chk("out_tdata", lii_out_p0_tdata, e[71:8]);
          chk("out_tkeep", {56'b0, lii_out_p0_tkeep}, {56'b0, e[7:0]});
        end
      end
      if (!arst && pixel_stream_tvalid && pixel_stream_tready) begin
        if (pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix_unexpected actual=%h required=no word", pixel_stream_tdata);
        end else begin
          chk("pix_tdata", {40'b0, pixel_stream_tdata}, {40'b0, pix_q.pop_front()});
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    logic ok = 1'b0;
    int   guard = 0;
    frame_stream_tdata  = w;
    frame_stream_tvalid = 1'b1;
    while (!ok && guard < 50) begin
      @(negedge aclk);
      ok = frame_stream_tready;
      if (!ok) stall_cnt++;
      @(posedge aclk);
      #1;
      guard++;
    end
    frame_stream_tvalid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL word_timeout actual=stalled required=accepted word %h", w);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] dst);
    logic ok = 1'b0;
    int   guard = 0;
    lii_in_p0_tdata  = d;
    lii_in_p0_dst    = dst;
    lii_in_p0_tvalid = 1'b1;
    while (!ok && guard < 50) begin
      @(negedge aclk);
      ok = lii_in_p0_tready;
      @(posedge aclk);
      #1;
      guard++;
    end
    lii_in_p0_tvalid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=stalled required=accepted beat %h", d);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_tready"},  {63'b0, lii_in_p0_tready},    64'd1);
    chk({tag, "_pix_tvalid"}, {63'b0, pixel_stream_tvalid}, 64'd0);
    chk({tag, "_out_tvalid"}, {63'b0, lii_out_p0_tvalid},   64'd0);
    chk({tag, "_out_tkeep"},  {56'b0, lii_out_p0_tkeep},    64'd0);
    chk({tag, "_out_tdata"},  lii_out_p0_tdata,             64'd0);
    chk({tag, "_frm_tready"}, {63'b0, frame_stream_tready}, 64'd1);
    chk({tag, "_ce"},         {63'b0, ce},                  64'd1);
    chk({tag, "_drop_cnt"},   {48'b0, drop_cnt},            64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] dsts [5];
    arst = 1'b1;
    lii_in_p0_tdata = '0;
    lii_in_p0_tvalid = 1'b0;
    lii_in_p0_src = 8'h42;
    lii_in_p0_dst = 8'h00;
    lii_out_p0_tready = 1'b1;
    pixel_stream_tready = 1'b0;
    frame_stream_tdata = '0;
    frame_stream_tvalid = 1'b0;
    fork
      monitor();
    join_none
    tick(3);
    check_reset("rst");
    chk("out_src", {56'b0, lii_out_p0_src}, 64'h00);
    chk("out_dst", {56'b0, lii_out_p0_dst}, 64'h01);
    arst = 1'b0;
    tick(1);

    // Two full beats, no back-pressure.
    out_q.push_back({64'h0706050403020100, 8'hFF});
    out_q.push_back({64'h0F0E0D0C0B0A0908, 8'hFF});
    for (int i = 0; i < 16; i++) send_word(8'(i));
    tick(5);
    chk("t1_stalls", 64'(stall_cnt), 64'd0);
    chk("t1_drained", 64'(out_q.size()), 64'd0);

    // Fill FIFO while kernel input is stalled.
    for (int i = 0; i < 8; i++) begin
      send_beat({40'h5A5A5A5A5A, 24'h100000 + 24'(i)}, 8'h00);
      pix_q.push_back(24'h100000 + 24'(i));
    end
    lii_in_p0_tdata  = {40'h5A5A5A5A5A, 24'h1000FF};
    lii_in_p0_dst    = 8'h00;
    lii_in_p0_tvalid = 1'b1;
    @(negedge aclk);
    chk("t2_full_tready", {63'b0, lii_in_p0_tready}, 64'd0);
    chk("t2_pix_tvalid", {63'b0, pixel_stream_tvalid}, 64'd1);
    @(posedge aclk);
    #1;
    lii_in_p0_tvalid = 1'b0;
    pixel_stream_tready = 1'b1;
    tick(12);
    chk("t2_pix_drained", 64'(pix_q.size()), 64'd0);
    chk("t2_pix_empty", {63'b0, pixel_stream_tvalid}, 64'd0);

    // Destination filter.
    dsts = '{8'h05, 8'h00, 8'h05, 8'h00, 8'h05};
    for (int i = 0; i < 5; i++) begin
      send_beat({40'h0, 24'hABC000 + 24'(i)}, dsts[i]);
      if (dsts[i] == 8'h00) pix_q.push_back(24'hABC000 + 24'(i));
    end
    tick(5);
    chk("t3_drop_cnt", {48'b0, drop_cnt}, 64'd3);
    chk("t3_pix_drained", 64'(pix_q.size()), 64'd0);

    // Output back-pressure.
    lii_out_p0_tready = 1'b0;
    out_q.push_back({64'h1716151413121110, 8'hFF});
    out_q.push_back({64'h1F1E1D1C1B1A1918, 8'hFF});
    for (int i = 0; i < 16; i++) send_word(8'h10 + 8'(i));
    @(negedge aclk);
    chk("t4_frm_tready", {63'b0, frame_stream_tready}, 64'd0);
    chk("t4_ce", {63'b0, ce}, 64'd0);
    chk("t4_out_tvalid", {63'b0, lii_out_p0_tvalid}, 64'd1);
    chk("t4_hold_tdata0", lii_out_p0_tdata, 64'h1716151413121110);
    tick(5);
    @(negedge aclk);
    chk("t4_hold_tdata1", lii_out_p0_tdata, 64'h1716151413121110);
    chk("t4_hold_tkeep", {56'b0, lii_out_p0_tkeep}, 64'hFF);
    @(posedge aclk);
    #1;
    lii_out_p0_tready = 1'b1;
    tick(5);
    chk("t4_drained", 64'(out_q.size()), 64'd0);
    chk("t4_frm_tready_back", {63'b0, frame_stream_tready}, 64'd1);

    // Partial beat followed by idle.
`ifdef LII_PACK_TIMEOUT_EN
    out_q.push_back({64'h0000000000CCBBAA, 8'h07});
`endif
    send_word(8'hAA);
    send_word(8'hBB);
    send_word(8'hCC);
    tick(100);
    chk("t5_queue_empty", 64'(out_q.size()), 64'd0);
    chk("t5_out_tvalid", {63'b0, lii_out_p0_tvalid}, 64'd0);
    arst = 1'b1;
    tick(1);
    arst = 1'b0;

    // Reset mid-beat discards the partial accumulator.
    for (int i = 0; i < 5; i++) send_word(8'h20 + 8'(i));
    arst = 1'b1;
    tick(1);
    check_reset("t6");
    arst = 1'b0;
    tick(30);
    chk("t6_no_beat", {63'b0, lii_out_p0_tvalid}, 64'd0);
    out_q.push_back({64'h3736353433323130, 8'hFF});
    for (int i = 0; i < 8; i++) send_word(8'h30 + 8'(i));
    tick(5);
    chk("t6_after_drained", 64'(out_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
